// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 adder/subtractor pipeline stages.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    // IEEE-754 single-precision operand as seen on the wire
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Alignment stage control states
    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        SHIFT,
        DONE
    } align_state_t;

endpackage

// File: rtl/fp_rshift_sticky.sv
// Combinational right shift by 0..MAX_SH positions. Every bit pushed out
// below bit 0 is ORed into bit 0 so repeated small shifts give the same
// result as one large sticky shift.
module fp_rshift_sticky #(
    parameter int W         = 27,
    parameter int MAX_SH    = 4,
    parameter bit STICKY_EN = 1'b1
) (
    input  logic [W-1:0]                 data_i,
    input  logic [$clog2(MAX_SH+1)-1:0]  shamt_i,
    output logic [W-1:0]                 data_o
);
    localparam int SAW = $clog2(MAX_SH + 1);

    logic [W-1:0] cand [MAX_SH+1];

    generate
        for (genvar gi = 0; gi <= MAX_SH; gi++) begin : g_cand
            if (gi == 0) begin : g_zero
                assign cand[gi] = data_i;
            end else begin : g_shift
                logic lost;
                assign lost     = |data_i[gi-1:0];
                assign cand[gi] = (data_i >> gi) | {{(W-1){1'b0}}, lost & STICKY_EN};
            end
        end
    endgenerate

    // Pick the candidate matching the requested shift distance
    always_comb begin
        data_o = data_i;
        for (int k = 0; k <= MAX_SH; k++) begin
            if (shamt_i == SAW'(k)) begin
                data_o = cand[k];
            end
        end
    end

endmodule

// File: rtl/fp_align.sv
// FP32 add/sub exponent-compare and mantissa-alignment stage.
// Captures two operands, picks the larger magnitude, then shifts the smaller
// mantissa right a few places per cycle until both share the larger exponent.
// Build option: define ALIGN_STICKY_EN to keep guard/round/sticky bits in
// mant_small[2:0]; otherwise those bits are driven 0 (truncation).
module fp_align #(
    parameter int EXP_W         = fp_pkg::EXP_W,
    parameter int MAN_W         = fp_pkg::MAN_W,
    parameter int SHIFT_PER_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel,
    output logic                 sign1,
    output logic                 sign2,
    output logic [1:0]           op_out,
    output logic [EXP_W-1:0]     exp_out,
    output logic [MAN_W:0]       mant_big,
    output logic [MAN_W+3:0]     mant_small,
    output logic                 special
);
    import fp_pkg::*;

    localparam int MW  = MAN_W + 4;                   // {hidden, frac, G, R, S}
    localparam int RW  = $clog2(MW + 1);
    localparam int SAW = $clog2(SHIFT_PER_CYC + 1);
    localparam logic [EXP_W-1:0] D_MAX    = EXP_W'(MW);
    localparam logic [RW-1:0]    STEP_MAX = RW'(SHIFT_PER_CYC);
`ifdef ALIGN_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    align_state_t         state_q;
    logic [EXP_W+MAN_W:0] a_q, b_q;
    logic [1:0]           op_q;
    logic                 in_ready_q, out_valid_q, sel_q, sign1_q, sign2_q, special_q;
    logic [EXP_W-1:0]     exp_q;
    logic [MAN_W:0]       mant_big_q;
    logic [MW-1:0]        mant_small_q;
    logic [RW-1:0]        rem_q;

    logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b, eexp_big, eexp_small, diff, d_clamp;
    logic [MAN_W:0]   m_a, m_b, m_big, m_small;
    logic             a_ge_b, is_special;
    logic [RW-1:0]    d_rem, step;
    logic [SAW-1:0]   shamt;
    logic [MW-1:0]    mant_shifted;

    // Operand unpack, magnitude compare, swap and clamped exponent distance
    always_comb begin
        exp_a      = a_q[EXP_W+MAN_W-1:MAN_W];
        exp_b      = b_q[EXP_W+MAN_W-1:MAN_W];
        m_a        = {|exp_a, a_q[MAN_W-1:0]};
        m_b        = {|exp_b, b_q[MAN_W-1:0]};
        // Denormals sit at the same scale as exponent 1
        eexp_a     = (exp_a == '0) ? EXP_W'(1) : exp_a;
        eexp_b     = (exp_b == '0) ? EXP_W'(1) : exp_b;
        // {exp,frac} orders magnitudes directly; a tie keeps operand 1 as big
        a_ge_b     = a_q[EXP_W+MAN_W-1:0] >= b_q[EXP_W+MAN_W-1:0];
        eexp_big   = a_ge_b ? eexp_a : eexp_b;
        eexp_small = a_ge_b ? eexp_b : eexp_a;
        m_big      = a_ge_b ? m_a : m_b;
        m_small    = a_ge_b ? m_b : m_a;
        diff       = eexp_big - eexp_small;
        // Beyond MW places everything has collapsed into sticky anyway
        d_clamp    = (diff > D_MAX) ? D_MAX : diff;
        d_rem      = RW'(d_clamp);
        is_special = (&exp_a) | (&exp_b);
        step       = (rem_q < STEP_MAX) ? rem_q : STEP_MAX;
        shamt      = SAW'(step);
    end

    fp_rshift_sticky #(
        .W         (MW),
        .MAX_SH    (SHIFT_PER_CYC),
        .STICKY_EN (STICKY_EN)
    ) u_rshift (
        .data_i  (mant_small_q),
        .shamt_i (shamt),
        .data_o  (mant_shifted)
    );

    // Control FSM with all outputs registered
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            sel_q        <= 1'b0;
            sign1_q      <= 1'b0;
            sign2_q      <= 1'b0;
            special_q    <= 1'b0;
            exp_q        <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
            rem_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        op_q       <= op;
                        in_ready_q <= 1'b0;
                        state_q    <= COMPARE;
                    end
                end
                COMPARE: begin
                    sel_q        <= a_ge_b;
                    sign1_q      <= a_q[EXP_W+MAN_W];
                    sign2_q      <= b_q[EXP_W+MAN_W];
                    special_q    <= is_special;
                    exp_q        <= eexp_big;
                    mant_big_q   <= m_big;
                    mant_small_q <= {m_small, 3'b000};
                    rem_q        <= d_rem;
                    // Inf/NaN operands are passed on unaligned
                    if (is_special || d_rem == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    mant_small_q <= mant_shifted;
                    rem_q        <= rem_q - step;
                    if (rem_q == step) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign sel        = sel_q;
    assign sign1      = sign1_q;
    assign sign2      = sign2_q;
    assign op_out     = op_q;
    assign exp_out    = exp_q;
    assign mant_big   = mant_big_q;
    assign special    = special_q;
`ifdef ALIGN_STICKY_EN
    assign mant_small = mant_small_q;
`else
    assign mant_small = {mant_small_q[MW-1:3], 3'b000};
`endif

endmodule

// File: tb/tb_fp_align.sv
// Self-checking bench for fp_align: directed spec cases plus randomized
// transactions compared every cycle against an arithmetic reference model.
module tb_fp_align;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [1:0]  op_in = '0;

    logic        in_ready, out_valid, sel, sign1, sign2, special;
    logic [1:0]  op_out;
    logic [7:0]  exp_out;
    logic [23:0] mant_big;
    logic [26:0] mant_small;

    always #5 clk = ~clk;

    fp_align #(.SHIFT_PER_CYC(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a_in),
        .b          (b_in),
        .op         (op_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sel        (sel),
        .sign1      (sign1),
        .sign2      (sign2),
        .op_out     (op_out),
        .exp_out    (exp_out),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .special    (special)
    );

    typedef struct {
        bit        sel, s1, s2, sp;
        bit [1:0]  op;
        bit [7:0]  e;
        bit [23:0] mb;
        bit [26:0] ms;
        int        lat;
    } exp_t;

    // Reference: what the aligned result must be, straight from the IEEE rules
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic [1:0] opv);
        fp32_t  fa, fb, big, sml;
        exp_t   r;
        int     eb, es, d;
        longint ms0;
        fa    = av;
        fb    = bv;
        r.sel = ({fa.exp, fa.frac} >= {fb.exp, fb.frac});
        big   = r.sel ? fa : fb;
        sml   = r.sel ? fb : fa;
        eb    = (big.exp == 0) ? 1 : int'(big.exp);
        es    = (sml.exp == 0) ? 1 : int'(sml.exp);
        r.s1  = fa.sign;
        r.s2  = fb.sign;
        r.op  = opv;
        r.e   = 8'(eb);
        r.sp  = (fa.exp == 8'hFF) || (fb.exp == 8'hFF);
        r.mb  = {big.exp != 0, big.frac};
        ms0   = longint'({sml.exp != 0, sml.frac}) * 8;
        d     = eb - es;
        if (d > 27) d = 27;
        if (r.sp || d == 0) begin
            r.ms  = 27'(ms0);
            r.lat = 2;
        end else begin
            r.ms = 27'(ms0 >> d);
            if ((ms0 % (longint'(1) << d)) != 0) r.ms[0] = 1'b1;
            r.lat = 2 + (d + 3) / 4;
        end
`ifndef ALIGN_STICKY_EN
        r.ms[2:0] = 3'b000;
`endif
        return r;
    endfunction

    int   total = 0;
    int   bad = 0;
    int   tmo = 0;
    bit   tb_done = 0;
    bit   final_done = 0;
    bit   busy = 0;
    int   since = 0;
    exp_t cur;

    bit        lit_en = 0;
    bit        lit_sel;
    bit [7:0]  lit_e;
    bit [23:0] lit_mb;
    bit [26:0] lit_ms;
    int        lit_lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Single compare process: every negedge, DUT vs model
    always @(negedge clk) begin
        bit vexp;
        if (!rstn) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_flags", 32'({sel, sign1, sign2, special, op_out}), 32'd0);
            chk("rst_exp", 32'(exp_out), 32'd0);
            chk("rst_mant_big", 32'(mant_big), 32'd0);
            chk("rst_mant_small", 32'(mant_small), 32'd0);
            busy = 0;
        end else begin
            if (busy) since++;
            vexp = busy && (since >= cur.lat);
            chk("in_ready", 32'(in_ready), 32'(!busy));
            chk("out_valid", 32'(out_valid), 32'(vexp));
            if (vexp && out_valid) begin
                chk("sel", 32'(sel), 32'(cur.sel));
                chk("signs", 32'({sign1, sign2}), 32'({cur.s1, cur.s2}));
                chk("op_out", 32'(op_out), 32'(cur.op));
                chk("exp_out", 32'(exp_out), 32'(cur.e));
                chk("mant_big", 32'(mant_big), 32'(cur.mb));
                chk("mant_small", 32'(mant_small), 32'(cur.ms));
                chk("special", 32'(special), 32'(cur.sp));
            end
            if (vexp && out_ready) begin
                busy = 0;
            end else if (!busy && in_valid) begin
                cur   = model(a_in, b_in, op_in);
                busy  = 1;
                since = 0;
                if (lit_en) begin
                    chk("pin_sel", 32'(cur.sel), 32'(lit_sel));
                    chk("pin_exp", 32'(cur.e), 32'(lit_e));
                    chk("pin_mant_big", 32'(cur.mb), 32'(lit_mb));
                    chk("pin_mant_small", 32'(cur.ms), 32'(lit_ms));
                    chk("pin_latency", cur.lat, lit_lat);
                end
            end
            if (tb_done && !final_done) begin
                chk("driver_timeouts", tmo, 0);
                final_done = 1;
            end
        end
    end

    task automatic set_lit(input bit s, input bit [7:0] e, input bit [23:0] mb,
                           input bit [26:0] ms, input int lat);
        lit_sel = s;
        lit_e   = e;
        lit_mb  = mb;
        lit_ms  = ms;
        lit_lat = lat;
        lit_en  = 1;
    endtask

    // One full transaction; optionally stall in DONE and keep in_valid high
    task automatic txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] top,
                       input int stall, input bit hold_v);
        int w;
        a_in     = ta;
        b_in     = tb_v;
        op_in    = top;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 50) tmo++;
        @(posedge clk); #1;
        if (hold_v) begin
            a_in = $urandom;
            b_in = $urandom;
        end else begin
            in_valid = 1'b0;
        end
        w = 0;
        while (!out_valid && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (w >= 50) tmo++;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        lit_en    = 0;
    endtask

    initial begin
        int ea, eb2, delta, r;
        logic [31:0] ra, rb;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        set_lit(1'b0, 8'h80, 24'h800000, 27'h2000000, 3);
        txn(32'h3F800000, 32'h40000000, 2'd0, 0, 1'b0);
        set_lit(1'b1, 8'h80, 24'hC00000, 27'h4000000, 2);
        txn(32'h40400000, 32'h40000000, 2'd1, 0, 1'b0);
`ifdef ALIGN_STICKY_EN
        set_lit(1'b1, 8'h97, 24'h800000, 27'h0000005, 8);
`else
        set_lit(1'b1, 8'h97, 24'h800000, 27'h0000000, 8);
`endif
        txn(32'h4B800000, 32'h3F800001, 2'd2, 0, 1'b0);
`ifdef ALIGN_STICKY_EN
        set_lit(1'b1, 8'hFE, 24'h800000, 27'h0000001, 9);
`else
        set_lit(1'b1, 8'hFE, 24'h800000, 27'h0000000, 9);
`endif
        txn(32'h7F000000, 32'h3F800000, 2'd0, 0, 1'b0);
        // Stall in DONE with in_valid held high
        set_lit(1'b1, 8'h80, 24'hC00000, 27'h4000000, 2);
        txn(32'h40400000, 32'h40000000, 2'd3, 5, 1'b1);

        // Reset in the middle of the d=24 shift sequence
        a_in = 32'h4B800000; b_in = 32'h3F800001; op_in = 2'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rstn = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
        end

        for (int i = 0; i < 300; i++) begin
            ea = int'($urandom_range(0, 255));
            r  = int'($urandom_range(0, 9));
            if (r < 6)      delta = int'($urandom_range(0, 8));
            else if (r < 8) delta = int'($urandom_range(0, 30));
            else            delta = int'($urandom_range(0, 255));
            eb2 = ($urandom_range(0, 1) == 1) ? ea + delta : ea - delta;
            if (eb2 < 0)   eb2 = 0;
            if (eb2 > 255) eb2 = 255;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb2), 23'($urandom)};
            if (r == 9) rb = {~ra[31], ra[30:0]};
            txn(ra, rb, 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        tb_done = 1;
        for (int k = 0; k < 5 && !final_done; k++) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
